// File: rtl/bcd2bin_32.sv
// bcd2bin_32 - sequential 8-digit BCD to 32-bit binary converter
// (reverse double-dabble, one bit per cycle).
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - conversion request, sampled only while idle
//   bcd    - packed BCD operand, digit 7 in [31:28] .. digit 0 in [3:0]
//   busy   - high while converting (SHIFT and DONE states)
//   done   - one-cycle completion strobe
//   err    - operand contained a nibble > 9; valid with done
//   bin    - binary result, valid with done, held until the next start
module bcd2bin_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] bin
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] bcd_q,   bcd_d;
  logic [31:0] sr_q,    sr_d;
  logic [31:0] bin_q,   bin_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic [63:0] shifted;
  logic [31:0] bcd_corr;
  logic        bcd_invalid;

  // Any input nibble above 9 makes the operand invalid.
  always_comb begin
    bcd_invalid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bcd[i*4 +: 4] > 4'd9) begin
        bcd_invalid = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift the {bcd, binary} pair right,
  // then pull every BCD nibble that landed at >= 8 back down by 3 so the
  // next halving stays a valid decimal halving.
  always_comb begin
    shifted  = {bcd_q, sr_q} >> 1;
    bcd_corr = shifted[63:32];
    for (int unsigned i = 0; i < 8; i++) begin
      if (shifted[32 + i*4 +: 4] >= 4'd8) begin
        bcd_corr[i*4 +: 4] = shifted[32 + i*4 +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    sr_d    = sr_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = bcd;
          sr_d  = '0;
          cnt_d = '0;
          bin_d = '0;
          err_d = bcd_invalid;
          if (bcd_invalid) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        bcd_d = bcd_corr;
        sr_d  = shifted[31:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          bin_d   = shifted[31:0];
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      sr_q    <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      sr_q    <= sr_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = done_q;
  assign err  = err_q;
  assign bin  = bin_q;

endmodule

// File: doc/bcd2bin_32.md
BCD2BIN_32 -- requirements
Module: bcd2bin_32

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 8 BCD digits in, 32 binary bits out.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 bcd  input  32  packed BCD operand, digit 7 (most significant) in [31:28], digit 0 in [3:0]; sampled on accepted start.
REQ-006 busy  output  1  high while a conversion is in progress (states SHIFT and DONE).
REQ-007 done  output  1  one-cycle completion strobe.
REQ-008 err  output  1  invalid-operand flag, valid with done, held until next accepted start.
REQ-009 bin  output  32  unsigned binary result, valid with done, held until next accepted start.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 IDLE: start=1 SHALL be accepted; bcd SHALL be latched into an internal 32-bit BCD register; binary shift register and 5-bit iteration counter cleared; err and bin cleared.
REQ-012 If any latched nibble >9 at acceptance, the FSM SHALL go IDLE->DONE, skip SHIFT, set err=1 and keep bin=0.
REQ-013 Otherwise the FSM SHALL go IDLE->SHIFT.
REQ-014 SHIFT: each cycle the concatenation {bcd_reg, bin_reg} SHALL shift right 1 bit (bcd_reg LSB enters bin_reg MSB); after the shift each bcd_reg nibble >=8 SHALL be reduced by 3 (reverse double-dabble); both steps in one cycle.
REQ-015 SHIFT SHALL last exactly 32 cycles (counter 0..31); on count 31 the FSM SHALL go to DONE and load bin from the shifted binary register.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: done SHALL be high in the 33rd cycle after the accepting edge for valid input, and in the cycle immediately after the accepting edge for invalid input.
REQ-018 bin and err SHALL remain stable from done until the next accepted start.
REQ-019 start while busy=1 SHALL be ignored with no effect on state or outputs; bcd changes while busy SHALL have no effect.
REQ-020 start high in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted (back-to-back period 34 cycles).
REQ-021 Results SHALL be exact for all valid inputs 0..99,999,999; bin[31:27] SHALL always be 0 for valid input.
REQ-022 busy SHALL be combinational from state only (high in SHIFT and DONE); done SHALL be registered.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, internal registers=0, busy=0, done=0, err=0, bin=0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the conversion; no done SHALL be produced for it after release.
REQ-025 The first start on or after the first rising edge with rst_n=1 SHALL be accepted normally.

Verification
REQ-026 bcd=0x12345678, start pulse -> 33 cycles later done=1, bin=0x00BC614E, err=0; busy high for the 33 intervening cycles.
REQ-027 bcd=0x99999999 -> bin=0x05F5E0FF, err=0; bcd=0x00000000 -> bin=0, err=0; bcd=0x00000001 -> bin=1.
REQ-028 bcd=0x1234A678 -> done the next cycle, err=1, bin=0; next valid start clears err.
REQ-029 start with bcd=0x00000042, then start with bcd=0x00000099 asserted 10 cycles later -> second start ignored; result bin=0x2A.
REQ-030 rst_n low at SHIFT cycle 15 -> busy, done, bin, err all 0 immediately; no done follows release; next start converts correctly.
REQ-031 Randomized valid BCD operands, back-to-back starts -> every bin matches the decimal reference model; accepted starts 34 cycles apart.
